// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {Instr, PC, PCPlus4}.
// Optional same-cycle empty-queue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   Instr,
    input  logic [DATA_WIDTH-1:0]   PC,
    input  logic [DATA_WIDTH-1:0]   PCPlus4,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   InstrD,
    output logic [DATA_WIDTH-1:0]   PCD,
    output logic [DATA_WIDTH-1:0]   PCPlus4D,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc4;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            pass;
    logic            bypass;

    assign in_entry = '{instr: Instr, pc: PC, pc4: PCPlus4};
    assign head     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Derived from stored count only, so a same-cycle pop never frees a slot.
    assign in_ready = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming entry directly; consumed entries skip storage.
    assign pass   = empty && in_valid && !flush;
    assign bypass = pass && out_ready;
`else
    assign pass   = 1'b0;
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || pass;
    assign push      = in_valid && in_ready && !flush && !bypass;
    assign pop       = !empty && out_ready && !flush;

    // Head presentation; NOP bubble when nothing is valid.
    always_comb begin
        InstrD   = NOP;
        PCD      = '0;
        PCPlus4D = '0;
        if (!empty) begin
            InstrD   = head.instr;
            PCD      = head.pc;
            PCPlus4D = head.pc4;
        end else if (pass) begin
            InstrD   = in_entry.instr;
            PCD      = in_entry.pc;
            PCPlus4D = in_entry.pc4;
        end
    end

    // Pointer and occupancy state; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic [DW-1:0] pc4;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  Instr;
    logic [DW-1:0]  PC;
    logic [DW-1:0]  PCPlus4;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  InstrD;
    logic [DW-1:0]  PCD;
    logic [DW-1:0]  PCPlus4D;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;

    fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Expected visible head given model contents and current inputs.
    function automatic ent_t exp_head();
        ent_t e;
        if (q.size() > 0)                      e = q[0];
        else if (BYP && in_valid && !flush)    e = '{instr: Instr, pc: PC, pc4: PCPlus4};
        else                                   e = '{instr: NOP, pc: '0, pc4: '0};
        return e;
    endfunction

    function automatic logic exp_valid();
        return (q.size() > 0) || (BYP && in_valid && !flush);
    endfunction

    task automatic drive(input logic iv, input logic [DW-1:0] pc, input logic fl, input logic ordy);
        in_valid  = iv;
        PC        = pc;
        PCPlus4   = pc + 32'd4;
        Instr     = $urandom;
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    // Apply one clock edge to both the model and the DUT.
    task automatic advance();
        bit byp_take;
        bit do_pop;
        bit do_push;
        ent_t e;
        e = '{instr: Instr, pc: PC, pc4: PCPlus4};
        if (rst || flush) begin
            q.delete();
        end else begin
            byp_take = BYP && q.size() == 0 && in_valid && out_ready;
            do_pop   = q.size() > 0 && out_ready;
            do_push  = in_valid && q.size() < DEPTH && !byp_take;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        advance();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b out_valid=%b in_ready=%b, want 0 1 0 0 1",
                     count, empty, full, out_valid, in_ready);
        end
        tests++;
        if (InstrD !== NOP || PCD !== '0 || PCPlus4D !== '0) begin
            fails++;
            $display("FAIL reset_nop: InstrD=%h PCD=%h PCPlus4D=%h, want %h 0 0", InstrD, PCD, PCPlus4D, NOP);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(i * 4), 1'b0, 1'b0);
            tests++;
            if (in_ready !== 1'b1 || count !== CW'(i)) begin
                fails++;
                $display("FAIL fill_%0d: in_ready=%b count=%0d, want 1 %0d", i, in_ready, count, i);
            end
            advance();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tests++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(4)) begin
            fails++;
            $display("FAIL fill_full: full=%b in_ready=%b count=%0d, want 1 0 4", full, in_ready, count);
        end
        advance();
        tests++;
        if (count !== CW'(4) || PCD !== 32'h0) begin
            fails++;
            $display("FAIL fill_refuse: count=%0d PCD=%h, want 4 0", count, PCD);
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] want_instr;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            want_instr = q[0].instr;
            tests++;
            if (out_valid !== 1'b1 || PCD !== DW'(i * 4) || InstrD !== want_instr || PCPlus4D !== DW'(i * 4 + 4)) begin
                fails++;
                $display("FAIL drain_%0d: valid=%b PCD=%h InstrD=%h PCPlus4D=%h, want 1 %h %h %h",
                         i, out_valid, PCD, InstrD, PCPlus4D, i * 4, want_instr, i * 4 + 4);
            end
            advance();
        end
        tests++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || InstrD !== NOP) begin
            fails++;
            $display("FAIL drain_empty: empty=%b valid=%b InstrD=%h, want 1 0 %h", empty, out_valid, InstrD, NOP);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 32'h100, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h104, 1'b0, 1'b0); advance();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(32'h108 + i * 4), 1'b0, 1'b1);
            tests++;
            if (count !== CW'(2) || out_valid !== 1'b1 || PCD !== DW'(32'h100 + i * 4)) begin
                fails++;
                $display("FAIL pushpop_%0d: count=%0d valid=%b PCD=%h, want 2 1 %h", i, count, out_valid, PCD, 32'h100 + i * 4);
            end
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== CW'(2) || PCD !== 32'h128) begin
            fails++;
            $display("FAIL pushpop_end: count=%0d PCD=%h, want 2 128", count, PCD);
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 32'h0, 1'b1, 1'b0); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h200 + i * 4), 1'b0, 1'b0);
            advance();
        end
        drive(1'b1, 32'hDEAD_0000, 1'b1, 1'b1);
        tests++;
        if (count !== CW'(3)) begin
            fails++;
            $display("FAIL flush_pre: count=%0d, want 3", count);
        end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tests++;
        if (count !== CW'(0) || out_valid !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL flush_post: count=%0d valid=%b empty=%b, want 0 0 1", count, out_valid, empty);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_valid !== 1'b0 || PCD === 32'hDEAD_0000) begin
                fails++;
                $display("FAIL flush_drop_%0d: valid=%b PCD=%h, want 0 and not dead0000", i, out_valid, PCD);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h400, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h404, 1'b0, 1'b0); advance();
        tests++;
        if (count !== CW'(2)) begin
            fails++;
            $display("FAIL rstmid_pre: count=%0d, want 2", count);
        end
        rst = 1'b1;
        drive(1'b1, 32'h408, 1'b1, 1'b1);
        advance();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests++;
        if (count !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || InstrD !== NOP) begin
            fails++;
            $display("FAIL rstmid_post: count=%0d empty=%b full=%b valid=%b in_ready=%b InstrD=%h, want 0 1 0 0 1 %h",
                     count, empty, full, out_valid, in_ready, InstrD, NOP);
        end
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h300, 1'b0, 1'b1);
        tests++;
        if (out_valid !== BYP || PCD !== (BYP ? 32'h300 : 32'h0)) begin
            fails++;
            $display("FAIL lat_same: valid=%b PCD=%h, want %b %h", out_valid, PCD, BYP, BYP ? 32'h300 : 32'h0);
        end
        advance();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tests++;
        if (out_valid !== !BYP || count !== (BYP ? CW'(0) : CW'(1)) || PCD !== (BYP ? 32'h0 : 32'h300)) begin
            fails++;
            $display("FAIL lat_next: valid=%b count=%0d PCD=%h, want %b %0d %h",
                     out_valid, count, PCD, !BYP, BYP ? 0 : 1, BYP ? 32'h0 : 32'h300);
        end
        advance();
    endtask

    task automatic test_random();
        ent_t          eh;
        logic [DW-1:0] pc_next = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 2) != 0), pc_next, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
            pc_next = pc_next + 32'd4;
            eh = exp_head();
            tests++;
            if (out_valid !== exp_valid() || {InstrD, PCD, PCPlus4D} !== eh) begin
                fails++;
                $display("FAIL rand_head_%0d: valid=%b PCD=%h InstrD=%h, want %b %h %h",
                         c, out_valid, PCD, InstrD, exp_valid(), eh.pc, eh.instr);
            end
            tests++;
            if (count !== CW'(q.size()) || in_ready !== (q.size() < DEPTH) || full !== (q.size() == DEPTH)) begin
                fails++;
                $display("FAIL rand_occ_%0d: count=%0d in_ready=%b full=%b, want %0d %b %b",
                         c, count, in_ready, full, q.size(), q.size() < DEPTH, q.size() == DEPTH);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_drain();
        test_push_pop();
        test_flush();
        test_reset_mid();
        test_latency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of instruction and PC fields.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  fetch presents a valid instruction this cycle.
REQ-006 in_ready  output  1  queue can accept an entry this cycle.
REQ-007 Instr  input  DATA_WIDTH  fetched instruction word.
REQ-008 PC  input  DATA_WIDTH  address of Instr.
REQ-009 PCPlus4  input  DATA_WIDTH  PC + 4 for Instr.
REQ-010 flush  input  1  discard all entries (taken branch or jump).
REQ-011 out_valid  output  1  head entry is valid for decode.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 InstrD, PCD, PCPlus4D  output  DATA_WIDTH each  head entry fields.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-015 full, empty  output  1 each  count == DEPTH, count == 0.

Function
REQ-016 Push occurs when in_valid && in_ready && !flush; stores {Instr, PC, PCPlus4} at write pointer, which then increments modulo DEPTH.
REQ-017 Pop occurs when out_valid && out_ready && !flush; read pointer increments modulo DEPTH.
REQ-018 in_ready = !full; in_ready SHALL NOT depend combinationally on out_ready, so a push to a full queue is refused even if a pop occurs that cycle.
REQ-019 out_valid = !empty (in the default build); head fields come from the read pointer entry.
REQ-020 When out_valid is 0, InstrD SHALL be 32'h00000013 (addi x0,x0,0 NOP), and PCD and PCPlus4D SHALL be 0.
REQ-021 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-022 Push only: count +1; pop only: count -1; neither: state held.
REQ-023 flush has priority over push and pop; next cycle count = 0, both pointers = 0, and the input presented during the flush cycle is dropped.
REQ-024 Pointers wrap from DEPTH-1 to 0 with no data loss; order is strictly FIFO.
REQ-025 Minimum latency from push to out_valid is 1 cycle (default build).
REQ-026 Storage contents need no reset; only pointers and count are reset.

Reset
REQ-027 When rst is 1 at a rising edge, next cycle count = 0, pointers = 0, empty = 1, full = 0, out_valid = 0, in_ready = 1.
REQ-028 rst has priority over flush, push and pop; reset mid-stream discards all entries.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN: when defined, if empty && in_valid && out_ready && !flush, the input is presented on the outputs in the same cycle with out_valid = 1 and is not stored; count stays 0.
REQ-030 With the bypass and empty && in_valid && !out_ready, out_valid = 1 with the input data, and the entry is stored normally.
REQ-031 Without FETCH_QUEUE_BYPASS_EN, no combinational path exists from the inputs to out_valid or the data outputs, and the REQ-025 latency applies.

Verification
REQ-032 After rst, push 4 entries (PC 0x0,0x4,0x8,0xC) with out_ready=0 -> full=1, in_ready=0, count=4; a 5th push is refused.
REQ-033 From full, hold out_ready=1 and in_valid=0 -> InstrD/PCD drain in the order 0x0,0x4,0x8,0xC; then empty=1 and InstrD=0x00000013.
REQ-034 With count=2, do a simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, and the output PC sequence has no gaps.
REQ-035 With count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle input is never output.
REQ-036 Assert rst while count=2 and flush=1 -> reset values are as in REQ-027 on the next cycle.
REQ-037 With the bypass defined, push to an empty queue with out_ready=1 -> out_valid=1 and PCD=PC in the same cycle, and count remains 0; without the bypass, out_valid rises one cycle later.
